// File: rtl/gray_updown_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : gray_updown_counter                                        |
// | Description : Up/down binary counter with a registered Gray-code copy.   |
// |               Supports synchronous clear and load (clr > load > en),     |
// |               wrap-around or saturation at the range ends, and a         |
// |               one-cycle registered wrap pulse.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   WIDTH    : counter width in bits, 2..16                                |
// |   SAT      : 0 = wrap at the range ends, 1 = saturate at the range ends  |
// | Ports                                                                    |
// |   clk      : in  1     clock, all updates on the rising edge             |
// |   rst_n    : in  1     asynchronous active-low reset                     |
// |   en       : in  1     count enable                                      |
// |   up       : in  1     direction, 1 = increment, 0 = decrement           |
// |   clr      : in  1     synchronous clear to zero (highest priority)      |
// |   load     : in  1     synchronous load of load_val                      |
// |   load_val : in  WIDTH binary value to load                              |
// |   bin_q    : out WIDTH registered binary count                           |
// |   gray_q   : out WIDTH registered Gray code of bin_q (flop output only)  |
// |   wrap     : out 1     registered one-cycle pulse on a wrap event        |
// |   at_max   : out 1     bin_q is all ones                                 |
// |   at_min   : out 1     bin_q is zero                                     |
// +--------------------------------------------------------------------------+
module gray_updown_counter #(
    parameter int WIDTH = 3,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_MAX  = '1;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_bin_inc;
    logic [WIDTH-1:0] w_bin_dec;
    logic             w_end_hit;
    logic [WIDTH-1:0] w_count_bin;
    logic             w_count_wrap;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_wrap_nxt;

    assign w_at_max  = (r_bin == c_MAX);
    assign w_at_min  = (r_bin == c_ZERO);
    assign w_bin_inc = r_bin + c_ONE;
    assign w_bin_dec = r_bin - c_ONE;

    // A count step that would cross a range end in its current direction.
    assign w_end_hit = up ? w_at_max : w_at_min;

    // Behaviour at the range ends. The plain modulo increment/decrement
    // already lands on the opposite end, so wrap mode only needs the pulse.
    generate
        if (SAT) begin : g_sat
            assign w_count_bin  = w_end_hit ? r_bin : (up ? w_bin_inc : w_bin_dec);
            assign w_count_wrap = 1'b0;
        end else begin : g_wrap
            assign w_count_bin  = up ? w_bin_inc : w_bin_dec;
            assign w_count_wrap = w_end_hit;
        end
    endgenerate

    // Next-state selection: clr > load > en > hold. Clear and load never
    // raise wrap, which also suppresses a wrap from a simultaneous count.
    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        if (clr) begin
            w_bin_nxt = c_ZERO;
        end else if (load) begin
            w_bin_nxt = load_val;
        end else if (en) begin
            w_bin_nxt  = w_count_bin;
            w_wrap_nxt = w_count_wrap;
        end
    end

    // Gray value is derived from the same next-state binary so both
    // registers always agree after every edge.
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= c_ZERO;
            r_gray <= c_ZERO;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bin_q  = r_bin;
    assign gray_q = r_gray;
    assign wrap   = r_wrap;
    assign at_max = w_at_max;
    assign at_min = w_at_min;

endmodule
`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_gray_updown_counter                                     |
// | Description : Self-checking bench for gray_updown_counter, WIDTH=3, with |
// |               one wrapping and one saturating instance on shared inputs. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gray_updown_counter;

    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         en       = 1'b0;
    logic         up       = 1'b0;
    logic         clr      = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] b0, g0, b1, g1;
    logic         w0, mx0, mn0, w1, mx1, mn1;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(W), .SAT(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bin_q(b0), .gray_q(g0), .wrap(w0),
        .at_max(mx0), .at_min(mn0)
    );

    gray_updown_counter #(.WIDTH(W), .SAT(1'b1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bin_q(b1), .gray_q(g1), .wrap(w1),
        .at_max(mx1), .at_min(mn1)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         wrap;
        logic         amax;
        logic         amin;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   m0     = 0;   // reference count, wrapping instance
    int   m1     = 0;   // reference count, saturating instance

    function automatic logic [W-1:0] gray_of(input int b);
        logic [W-1:0] v;
        logic [W-1:0] r;
        v = W'(b);
        r[W-1] = v[W-1];
        for (int i = 0; i < W - 1; i++) r[i] = v[i] ^ v[i+1];
        return r;
    endfunction

    task automatic model(input int sat, input int cur, input bit ce, input bit cu,
                         input bit cc, input bit cl, input int clv,
                         output int nxt, output exp_t e);
        int n;
        bit w;
        n = cur;
        w = 1'b0;
        if (cc) n = 0;
        else if (cl) n = clv;
        else if (ce) begin
            n = cu ? cur + 1 : cur - 1;
            if (n > MAXV || n < 0) begin
                if (sat != 0) n = cur;
                else begin
                    n = (n + MAXV + 1) % (MAXV + 1);
                    w = 1'b1;
                end
            end
        end
        e.bin  = W'(n);
        e.gray = gray_of(n);
        e.wrap = w;
        e.amax = (n == MAXV);
        e.amin = (n == 0);
        nxt    = n;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [W-1:0] b,
                           input logic [W-1:0] g, input logic w, input logic mx,
                           input logic mn);
        chk({tag, ".bin"},    16'(b),  16'(e.bin));
        chk({tag, ".gray"},   16'(g),  16'(e.gray));
        chk({tag, ".wrap"},   16'(w),  16'(e.wrap));
        chk({tag, ".at_max"}, 16'(mx), 16'(e.amax));
        chk({tag, ".at_min"}, 16'(mn), 16'(e.amin));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".w.bin"},  16'(b0),  16'h0);
        chk({tag, ".w.gray"}, 16'(g0),  16'h0);
        chk({tag, ".w.wrap"}, 16'(w0),  16'h0);
        chk({tag, ".w.min"},  16'(mn0), 16'h1);
        chk({tag, ".w.max"},  16'(mx0), 16'h0);
        chk({tag, ".s.bin"},  16'(b1),  16'h0);
        chk({tag, ".s.gray"}, 16'(g1),  16'h0);
        chk({tag, ".s.wrap"}, 16'(w1),  16'h0);
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare
    // one time unit after the edge.
    task automatic step(input bit ce, input bit cu, input bit cc, input bit cl,
                        input logic [W-1:0] lv, input string tag);
        exp_t         e;
        int           n;
        logic [W-1:0] g0_prev, g1_prev;
        en = ce; up = cu; clr = cc; load = cl; load_val = lv;
        model(0, m0, ce, cu, cc, cl, int'(lv), n, e); m0 = n; q0.push_back(e);
        model(1, m1, ce, cu, cc, cl, int'(lv), n, e); m1 = n; q1.push_back(e);
        g0_prev = g0;
        g1_prev = g1;
        @(posedge clk);
        #1;
        e = q0.pop_front();
        compare({tag, "/w"}, e, b0, g0, w0, mx0, mn0);
        e = q1.pop_front();
        compare({tag, "/s"}, e, b1, g1, w1, mx1, mn1);
        if (ce && !cc && !cl) begin
            chk({tag, "/w.gray_1bit"}, 16'($countones(g0 ^ g0_prev)), 16'h1);
            chk({tag, "/s.gray_le1"},  16'($countones(g1 ^ g1_prev) <= 1), 16'h1);
        end
    endtask

    logic [W-1:0] s1_bin [9];
    logic [W-1:0] s1_gray[9];

    initial begin
        s1_bin  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        s1_gray = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0, 3'd1};

        // Reset takes effect before any clock edge.
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_async0");
        @(posedge clk); #1;
        chk_reset_outputs("rst_held");
        rst_n = 1'b1;
        m0 = 0; m1 = 0;

        // Up count from reset through a wrap.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "up9");
            chk("up9.bin",  16'(b0), 16'(s1_bin[i]));
            chk("up9.gray", 16'(g0), 16'(s1_gray[i]));
            chk("up9.wrap", 16'(w0), 16'(s1_bin[i] == 3'd0));
        end

        // Down through zero.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, "ld0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "dn1");
        chk("dn1.bin", 16'(b0), 16'd7); chk("dn1.gray", 16'(g0), 16'd4); chk("dn1.wrap", 16'(w0), 16'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "dn2");
        chk("dn2.bin", 16'(b0), 16'd6); chk("dn2.gray", 16'(g0), 16'd5); chk("dn2.wrap", 16'(w0), 16'd0);

        // Saturation at max.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, "ld6");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "satup");
            chk("satup.bin", 16'(b1), 16'd7); chk("satup.max", 16'(mx1), 16'd1); chk("satup.wrap", 16'(w1), 16'd0);
        end
        // Saturation at min.
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "clr");
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "satdn");
        chk("satdn.bin", 16'(b1), 16'd0); chk("satdn.wrap", 16'(w1), 16'd0);

        // Priority clr > load > en, then load alone.
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, "prio");
        chk("prio.bin", 16'(b0), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, "ld5");
        chk("ld5.bin", 16'(b0), 16'd5); chk("ld5.gray", 16'(g0), 16'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, "ld5same");
        chk("ld5same.bin", 16'(b0), 16'd5); chk("ld5same.wrap", 16'(w0), 16'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "hold_up_dc");
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "hold_dn_dc");

        // Clear or load alongside a would-be wrap suppresses the pulse.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, "ld7a");
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, "clr_wrap");
        chk("clr_wrap.wrap", 16'(w0), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, "ld7b");
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, "ld_wrap");
        chk("ld_wrap.bin", 16'(b0), 16'd3); chk("ld_wrap.wrap", 16'(w0), 16'd0);

        // Asynchronous reset between edges while counting at 4.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, "ld4");
        chk("ld4.bin", 16'(b0), 16'd4);
        en = 1'b1; up = 1'b1; load = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        m0 = 0; m1 = 0;
        @(posedge clk); #1;
        chk_reset_outputs("rst_override");
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "resume");
        chk("resume.bin", 16'(b0), 16'd1);

        // Reset during a wrap pulse aborts it.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, "ld7c");
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "wrapup");
        chk("wrapup.wrap", 16'(w0), 16'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_wrap");
        m0 = 0; m1 = 0;
        #1 rst_n = 1'b1;

        // Random traffic against the reference model.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
